seq_mul_unit: RTL and testbench
===============================

// Module: seq_mul_unit
// PURPOSE
//  Parametrised sequential sign-magnitude fixed-point multiplier for the IIR datapath.
//  Shift-add core, one partial product per cycle, valid/ready handshake on both sides.
//  Rescales the 2W-bit product back to W bits in the Qm.F format (truncate or round).
//  Saturates on overflow and suppresses negative zero. Sits between coefficient/sample
//  registers and the accumulator.
// PARAMETERS
//  W      8  magnitude width of operands and result (W >= 2)
//  F      4  fractional bits of operands and result (0 <= F < W)
//  ROUND  0  0 = truncate on rescale; 1 = round-half-up (add 2^(F-1) before shift; ignored if F=0)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    synchronous reset, active low
//  in_valid   in   1    operand set presented
//  in_ready   out  1    unit can accept operands
//  operA      in   W    magnitude of operand A
//  operB      in   W    magnitude of operand B
//  signA      in   1    sign of A (1 = negative)
//  signB      in   1    sign of B
//  out_valid  out  1    result available
//  out_ready  in   1    consumer takes result
//  result     out  W    rescaled, saturated magnitude
//  product    out  2W   full unscaled magnitude product operA*operB
//  overflow   out  1    rescaled magnitude exceeded 2^W-1 (result saturated)
//  sign       out  1    signA^signB, forced 0 when result==0
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state IDLE, counter 0, all datapath regs 0; out_valid=0,
//    result=0, product=0, overflow=0, sign=0, busy=0, in_ready=1 after the edge.
//    Reset mid-operation aborts it; no result is produced.
//  - FSM IDLE -> RUN on in_valid&&in_ready. RUN -> DONE after exactly W RUN cycles.
//    DONE -> IDLE on out_ready. No other transitions.
//  - in_ready = (state==IDLE). out_valid = (state==DONE). in_valid outside IDLE is ignored.
//  - On accept: latch mcand={W'b0,operA} (2W), mplier=operB, sgn=signA^signB, acc=0, cnt=0.
//    Later operand changes have no effect.
//  - Each RUN cycle: if mplier[0], acc += mcand; mcand <<= 1; mplier >>= 1; cnt++.
//    Fixed W cycles; no early exit.
//  - RUN->DONE edge registers from final acc:
//    product = acc;
//    t = acc + (ROUND && F>0 ? 2^(F-1) : 0) (2W+1 bits);
//    s = t >> F;
//    overflow = (s > 2^W-1);
//    result = overflow ? all-ones : s[W-1:0];
//    sign = sgn && (result != 0).
//  - Latency: out_valid rises W+1 cycles after the input handshake cycle. Outputs are held
//    stable while out_valid && !out_ready (unbounded backpressure).
//  - Throughput: one op per W+2 cycles minimum. A new accept is possible in the cycle after
//    the output handshake.
//  - result/product/overflow/sign keep their last values in IDLE/RUN until the next DONE
//    entry; consumers qualify with out_valid.
//  - Width rules: unsigned magnitude arithmetic only; acc never wraps (max (2^W-1)^2 < 2^2W).
//    The rounding add uses W*2+1 bits.
// STRUCTURE
//  - Package mul_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
//    localparams ROUND_TRUNC=0, ROUND_HALF_UP=1.
//  - Sub-module mul_scaler (combinational, params W, F, ROUND): acc[2W-1:0] ->
//    result[W-1:0], overflow. Instanced once.
//  - Counter width $clog2(W+1).
// TESTING (W=8, F=4 unless stated)
//  1. operA=0x18, operB=0x20, signs 0/0 -> after 9 cycles product=0x0300, result=0x30,
//     overflow=0, sign=0.
//  2. operA=0xFF, operB=0xFF -> product=0xFE01, result=0xFF, overflow=1; with signA=1,
//     sign=1.
//  3. operA=0x01, operB=0x08: ROUND=0 -> result=0x00, sign=0 even with signA=1;
//     ROUND=1 -> result=0x01.
//  4. operA=0x00, operB=0x55, signA=1, signB=0 -> result=0, sign=0, overflow=0.
//  5. Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable,
//     in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
//  6. rst_n=0 on 3rd RUN cycle -> next cycle IDLE, out_valid=0, all outputs 0, no result
//     emitted; W=16, F=8 random sweep vs reference model.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential sign-magnitude multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int unsigned ROUND_TRUNC   = 0;
  localparam int unsigned ROUND_HALF_UP = 1;

endpackage

// File: rtl/mul_scaler.sv
// Rescales a 2W-bit magnitude product back to Qm.F width with optional
// round-half-up and saturation to all-ones on overflow.
module mul_scaler
  import mul_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned F     = 4,
  parameter int unsigned ROUND = ROUND_TRUNC
) (
  input  logic [2*W-1:0] acc,
  output logic [W-1:0]   result,
  output logic           overflow
);

  localparam int unsigned TW  = 2 * W + 1;
  localparam int unsigned RSH = (F > 0) ? F - 1 : 0;
  localparam logic [TW-1:0] RND = (ROUND == ROUND_HALF_UP && F > 0) ? (TW'(1) << RSH) : '0;

  logic [TW-1:0] t_c;
  logic [TW-1:0] s_c;

  // Extra top bit keeps the rounding add from wrapping at full-scale inputs.
  always_comb begin
    t_c      = {1'b0, acc} + RND;
    s_c      = t_c >> F;
    overflow = |s_c[TW-1:W];
    result   = overflow ? '1 : s_c[W-1:0];
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Shift-add sign-magnitude multiplier: one partial product per cycle, fixed W
// iterations, rescaled/saturated result held until the consumer takes it.
module seq_mul_unit
  import mul_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned F     = 4,
  parameter int unsigned ROUND = ROUND_TRUNC
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   operA,
  input  logic [W-1:0]   operB,
  input  logic           signA,
  input  logic           signB,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   result,
  output logic [2*W-1:0] product,
  output logic           overflow,
  output logic           sign,
  output logic           busy
);

  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam int unsigned PW    = 2 * W;

  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [W-1:0]     result_q, result_d;
  logic             sgn_q, sgn_d;
  logic             overflow_q, overflow_d;
  logic             sign_q, sign_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [PW-1:0]    acc_step_c;
  logic [W-1:0]     scl_result_c;
  logic             scl_overflow_c;

  // Accumulator value after this cycle's partial product; kept separate so the
  // scaler sees the final sum on the last RUN cycle without a combinational loop.
  always_comb begin
    acc_step_c = mplier_q[0] ? acc_q + mcand_q : acc_q;
  end

  mul_scaler #(
    .W    (W),
    .F    (F),
    .ROUND(ROUND)
  ) u_scaler (
    .acc     (acc_step_c),
    .result  (scl_result_c),
    .overflow(scl_overflow_c)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    sgn_d      = sgn_q;
    product_d  = product_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    sign_d     = sign_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = RUN;
          mcand_d  = {W'(0), operA};
          mplier_d = operB;
          sgn_d    = signA ^ signB;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_d    = acc_step_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d    = DONE;
          product_d  = acc_step_c;
          result_d   = scl_result_c;
          overflow_d = scl_overflow_c;
          sign_d     = sgn_q && (scl_result_c != '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      sgn_q       <= 1'b0;
      product_q   <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      sgn_q       <= sgn_d;
      product_q   <= product_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      sign_q      <= sign_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign product   = product_q;
  assign overflow  = overflow_q;
  assign sign      = sign_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Bench for seq_mul_unit: directed corner cases on W=8/F=4 (truncate and round)
// plus a random sweep of W=16/F=8 against an arithmetic reference model.
module tb_seq_mul_unit;

  logic clk;
  logic rst_n;

  logic       in_valid, out_ready, s_a, s_b;
  logic [7:0] op_a, op_b;
  logic       rdy_t, vld_t, ovf_t, sgn_t, busy_t;
  logic [7:0] res_t;
  logic [15:0] prod_t;
  logic       rdy_r, vld_r, ovf_r, sgn_r, busy_r;
  logic [7:0] res_r;
  logic [15:0] prod_r;

  logic        in_valid_w, out_ready_w, s_a_w, s_b_w;
  logic [15:0] op_a_w, op_b_w;
  logic        rdy_w, vld_w, ovf_w, sgn_w, busy_w;
  logic [15:0] res_w;
  logic [31:0] prod_w;

  int checks = 0;
  int failures = 0;

  seq_mul_unit #(.W(8), .F(4), .ROUND(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_t),
    .operA(op_a), .operB(op_b), .signA(s_a), .signB(s_b),
    .out_valid(vld_t), .out_ready(out_ready), .result(res_t), .product(prod_t),
    .overflow(ovf_t), .sign(sgn_t), .busy(busy_t)
  );

  seq_mul_unit #(.W(8), .F(4), .ROUND(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_r),
    .operA(op_a), .operB(op_b), .signA(s_a), .signB(s_b),
    .out_valid(vld_r), .out_ready(out_ready), .result(res_r), .product(prod_r),
    .overflow(ovf_r), .sign(sgn_r), .busy(busy_r)
  );

  seq_mul_unit #(.W(16), .F(8), .ROUND(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(rdy_w),
    .operA(op_a_w), .operB(op_b_w), .signA(s_a_w), .signB(s_b_w),
    .out_valid(vld_w), .out_ready(out_ready_w), .result(res_w), .product(prod_w),
    .overflow(ovf_w), .sign(sgn_w), .busy(busy_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product, optional half-LSB bias, shift, clamp.
  function automatic void model(input int unsigned w, input int unsigned f, input int unsigned rnd,
                                input longint unsigned a, input longint unsigned b,
                                input bit sa, input bit sb,
                                output longint unsigned p, output longint unsigned res,
                                output bit ovf, output bit sg);
    longint unsigned t, s, maxv;
    p    = a * b;
    t    = p + ((rnd != 0 && f > 0) ? (64'd1 << (f - 1)) : 64'd0);
    s    = t >> f;
    maxv = (64'd1 << w) - 64'd1;
    ovf  = (s > maxv);
    res  = ovf ? maxv : s;
    sg   = (sa ^ sb) && (res != 0);
  endfunction

  // Present one operand set to both W=8 units, wait for the result, compare to the model.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sa, input logic sb,
                      input bit no_sync);
    longint unsigned p, res;
    bit ovf, sg;
    int lat;
    if (!no_sync) @(negedge clk);
    in_valid = 1'b1; op_a = a; op_b = b; s_a = sa; s_b = sb;
    checks++;
    if (!(rdy_t === 1'b1 && rdy_r === 1'b1)) begin
      failures++;
      $display("FAIL run8_in_ready got %b/%b want 1/1", rdy_t, rdy_r);
    end
    @(negedge clk);
    in_valid = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); s_a = 1'($urandom); s_b = 1'($urandom);
    lat = 0;
    while (vld_t !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 8 || vld_r !== 1'b1) begin
      failures++;
      $display("FAIL run8_latency a=%h b=%h got %0d (vld_r=%b) want 8", a, b, lat, vld_r);
    end
    model(8, 4, 0, 64'(a), 64'(b), sa, sb, p, res, ovf, sg);
    checks++;
    if (prod_t !== 16'(p) || res_t !== 8'(res) || ovf_t !== ovf || sgn_t !== sg) begin
      failures++;
      $display("FAIL run8_trunc a=%h b=%h s=%b%b got p=%h r=%h o=%b s=%b want p=%h r=%h o=%b s=%b",
               a, b, sa, sb, prod_t, res_t, ovf_t, sgn_t, 16'(p), 8'(res), ovf, sg);
    end
    model(8, 4, 1, 64'(a), 64'(b), sa, sb, p, res, ovf, sg);
    checks++;
    if (prod_r !== 16'(p) || res_r !== 8'(res) || ovf_r !== ovf || sgn_r !== sg) begin
      failures++;
      $display("FAIL run8_round a=%h b=%h s=%b%b got p=%h r=%h o=%b s=%b want p=%h r=%h o=%b s=%b",
               a, b, sa, sb, prod_r, res_r, ovf_r, sgn_r, 16'(p), 8'(res), ovf, sg);
    end
  endtask

  task automatic release8();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (vld_t !== 1'b0 || rdy_t !== 1'b1 || busy_t !== 1'b0 || vld_r !== 1'b0) begin
      failures++;
      $display("FAIL release8 got vld=%b rdy=%b busy=%b vld_r=%b want 0 1 0 0",
               vld_t, rdy_t, busy_t, vld_r);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; op_a = 8'hA5; op_b = 8'h5A; s_a = 1'b1; s_b = 1'b0; out_ready = 1'b0;
    in_valid_w = 1'b1; op_a_w = 16'h1234; op_b_w = 16'h4321; s_a_w = 1'b1; s_b_w = 1'b0;
    out_ready_w = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy_t !== 1'b1 || vld_t !== 1'b0 || busy_t !== 1'b0 || res_t !== 8'h00 ||
        prod_t !== 16'h0000 || ovf_t !== 1'b0 || sgn_t !== 1'b0) begin
      failures++;
      $display("FAIL reset_w8 got rdy=%b vld=%b busy=%b r=%h p=%h o=%b s=%b",
               rdy_t, vld_t, busy_t, res_t, prod_t, ovf_t, sgn_t);
    end
    checks++;
    if (rdy_w !== 1'b1 || vld_w !== 1'b0 || busy_w !== 1'b0 || res_w !== 16'h0 ||
        prod_w !== 32'h0 || ovf_w !== 1'b0 || sgn_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_w16 got rdy=%b vld=%b busy=%b r=%h p=%h o=%b s=%b",
               rdy_w, vld_w, busy_w, res_w, prod_w, ovf_w, sgn_w);
    end
    in_valid = 1'b0;
    in_valid_w = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run8(8'h18, 8'h20, 1'b0, 1'b0, 1'b0);
    checks++;
    if (prod_t !== 16'h0300 || res_t !== 8'h30 || ovf_t !== 1'b0 || sgn_t !== 1'b0) begin
      failures++;
      $display("FAIL basic got p=%h r=%h o=%b s=%b want 0300 30 0 0", prod_t, res_t, ovf_t, sgn_t);
    end
    release8();
  endtask

  task automatic test_overflow();
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    checks++;
    if (prod_t !== 16'hFE01 || res_t !== 8'hFF || ovf_t !== 1'b1 || sgn_t !== 1'b1 ||
        res_r !== 8'hFF || ovf_r !== 1'b1) begin
      failures++;
      $display("FAIL overflow got p=%h r=%h o=%b s=%b rr=%h or=%b want FE01 FF 1 1 FF 1",
               prod_t, res_t, ovf_t, sgn_t, res_r, ovf_r);
    end
    release8();
  endtask

  task automatic test_round();
    run8(8'h01, 8'h08, 1'b1, 1'b0, 1'b0);
    checks++;
    if (res_t !== 8'h00 || sgn_t !== 1'b0 || res_r !== 8'h01 || sgn_r !== 1'b1) begin
      failures++;
      $display("FAIL round got rt=%h st=%b rr=%h sr=%b want 00 0 01 1", res_t, sgn_t, res_r, sgn_r);
    end
    release8();
  endtask

  task automatic test_zero();
    run8(8'h00, 8'h55, 1'b1, 1'b0, 1'b0);
    checks++;
    if (res_t !== 8'h00 || sgn_t !== 1'b0 || ovf_t !== 1'b0 || prod_t !== 16'h0000) begin
      failures++;
      $display("FAIL zero got r=%h s=%b o=%b p=%h want 00 0 0 0000", res_t, sgn_t, ovf_t, prod_t);
    end
    release8();
  endtask

  task automatic test_backpressure();
    logic [7:0]  r0;
    logic [15:0] p0;
    logic        o0, s0;
    int bad;
    run8(8'h9C, 8'h37, 1'b0, 1'b1, 1'b0);
    r0 = res_t; p0 = prod_t; o0 = ovf_t; s0 = sgn_t;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      op_a = 8'($urandom); op_b = 8'($urandom); s_a = 1'($urandom); s_b = 1'($urandom);
      @(negedge clk);
      if (vld_t !== 1'b1 || rdy_t !== 1'b0 || busy_t !== 1'b1 || res_t !== r0 ||
          prod_t !== p0 || ovf_t !== o0 || sgn_t !== s0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold got %0d unstable cycles want 0", bad);
    end
    release8();
    @(negedge clk);
    checks++;
    if (busy_t !== 1'b0 || vld_t !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_ignored got busy=%b vld=%b want 0 0", busy_t, vld_t);
    end
  endtask

  task automatic test_back_to_back();
    run8(8'h3C, 8'hC3, 1'b1, 1'b1, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    run8(8'h7F, 8'h81, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    run8(8'h11, 8'hEE, 1'b1, 1'b0, 1'b1);
    release8();
  endtask

  task automatic test_reset_mid();
    int seen;
    run8(8'h18, 8'h20, 1'b0, 1'b0, 1'b0);
    release8();
    @(negedge clk);
    in_valid = 1'b1; op_a = 8'hF0; op_b = 8'hF0; s_a = 1'b1; s_b = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy_t !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_running got busy=%b want 1", busy_t);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (vld_t !== 1'b0 || rdy_t !== 1'b1 || busy_t !== 1'b0 || res_t !== 8'h00 ||
        prod_t !== 16'h0000 || ovf_t !== 1'b0 || sgn_t !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got vld=%b rdy=%b busy=%b r=%h p=%h o=%b s=%b",
               vld_t, rdy_t, busy_t, res_t, prod_t, ovf_t, sgn_t);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (vld_t !== 1'b0 || busy_t !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_no_result got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_random8();
    for (int i = 0; i < 20; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      release8();
    end
  endtask

  task automatic test_sweep16();
    longint unsigned p, res;
    bit ovf, sg;
    logic [15:0] a, b;
    logic sa, sb;
    int lat, hold;
    for (int i = 0; i < 40; i++) begin
      case (i)
        0: begin a = 16'hFFFF; b = 16'hFFFF; end
        1: begin a = 16'h0001; b = 16'h0080; end
        2: begin a = 16'h0000; b = 16'hBEEF; end
        3: begin a = 16'h0100; b = 16'h00FF; end
        default: begin a = 16'($urandom); b = (i % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom); end
      endcase
      sa = 1'($urandom); sb = 1'($urandom);
      @(negedge clk);
      in_valid_w = 1'b1; op_a_w = a; op_b_w = b; s_a_w = sa; s_b_w = sb;
      @(negedge clk);
      in_valid_w = 1'b0; op_a_w = 16'($urandom); op_b_w = 16'($urandom);
      lat = 0;
      while (vld_w !== 1'b1 && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != 16) begin
        failures++;
        $display("FAIL sweep16_latency i=%0d got %0d want 16", i, lat);
      end
      model(16, 8, 1, 64'(a), 64'(b), sa, sb, p, res, ovf, sg);
      checks++;
      if (prod_w !== 32'(p) || res_w !== 16'(res) || ovf_w !== ovf || sgn_w !== sg) begin
        failures++;
        $display("FAIL sweep16 a=%h b=%h s=%b%b got p=%h r=%h o=%b s=%b want p=%h r=%h o=%b s=%b",
                 a, b, sa, sb, prod_w, res_w, ovf_w, sgn_w, 32'(p), 16'(res), ovf, sg);
      end
      hold = $urandom_range(0, 2);
      repeat (hold) @(negedge clk);
      out_ready_w = 1'b1;
      @(negedge clk);
      out_ready_w = 1'b0;
      checks++;
      if (vld_w !== 1'b0 || rdy_w !== 1'b1) begin
        failures++;
        $display("FAIL sweep16_release got vld=%b rdy=%b want 0 1", vld_w, rdy_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_round();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    test_sweep16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
